// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a flash-reading initiator and the flash responder.
// Framing: cs low brackets a transfer; mosi is sampled on sck rise, miso changes on sck fall (mode 0).
interface spi_flash_responder_if;
    logic cs;
    logic sck;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output cs,
        output sck,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  cs,
        input  sck,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Minimal serial-flash emulator (SPI mode 0 target): answers JEDEC ID, status and read commands.
// All SPI pins are oversampled on clk, so clk must run at least 4x sck.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
    parameter logic [7:0]  STATUS_VAL = 8'h00,
    parameter logic [7:0]  PATTERN    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_flash_responder_if.slave  spi,
    output logic                  cmd_strobe,
    output logic [7:0]            last_cmd,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_ID     = 3'd3,
        S_STAT   = 3'd4,
        S_DATA   = 3'd5,
        S_IGNORE = 3'd6
    } state_e;

    logic        cs_s1_q, cs_s2_q;
    logic        sck_s1_q, sck_s2_q, sck_s3_q;
    logic        mosi_s1_q, mosi_s2_q;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        miso_oe_q, miso_oe_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        busy_q, busy_d;

    logic        sck_rise, sck_fall, byte_done, tx_state;
    logic [7:0]  shift_nxt;
    logic [23:0] addr_nxt, addr_inc;

    // mosi and sck travel through matching stage counts, so mosi_s2 lines up with the rise detect.
    assign sck_rise  = sck_s2_q & ~sck_s3_q;
    assign sck_fall  = ~sck_s2_q & sck_s3_q;
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign shift_nxt = {shift_q[6:0], mosi_s2_q};
    assign addr_nxt  = {addr_q[22:0], mosi_s2_q};
    assign addr_inc  = addr_q + 24'd1;
    assign tx_state  = (state_q == S_ID) || (state_q == S_STAT) || (state_q == S_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            sck_s1_q     <= 1'b0;
            sck_s2_q     <= 1'b0;
            sck_s3_q     <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 8'h00;
            addr_q       <= 24'h000000;
            tx_q         <= 8'h00;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cmd_strobe_q <= 1'b0;
            last_cmd_q   <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            cs_s1_q      <= spi.cs;
            cs_s2_q      <= cs_s1_q;
            sck_s1_q     <= spi.sck;
            sck_s2_q     <= sck_s1_q;
            sck_s3_q     <= sck_s2_q;
            mosi_s1_q    <= spi.mosi;
            mosi_s2_q    <= mosi_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            cmd_strobe_q <= cmd_strobe_d;
            last_cmd_q   <= last_cmd_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        cmd_strobe_d = 1'b0;
        last_cmd_d   = last_cmd_q;
        busy_d       = busy_q;

        if (state_q == S_IDLE) begin
            if (!cs_s2_q) begin
                state_d    = S_CMD;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 2'd0;
                shift_d    = 8'h00;
                busy_d     = 1'b1;
            end
        end else if (cs_s2_q) begin
            // Deselect beats any sck edge seen in the same clk; partial bytes are dropped.
            state_d    = S_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            shift_d    = 8'h00;
            miso_d     = 1'b0;
            miso_oe_d  = 1'b0;
            busy_d     = 1'b0;
        end else begin
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = shift_nxt;
            end
            if (sck_fall && tx_state) begin
                miso_d    = tx_q[7];
                tx_d      = {tx_q[6:0], 1'b0};
                miso_oe_d = 1'b1;
            end

            // The next byte is loaded on the last rise so its MSB leaves on the following fall.
            case (state_q)
                S_CMD: begin
                    if (byte_done) begin
                        last_cmd_d   = shift_nxt;
                        cmd_strobe_d = 1'b1;
                        case (shift_nxt)
                            8'h9F: begin
                                state_d    = S_ID;
                                tx_d       = JEDEC_ID[23:16];
                                byte_cnt_d = 2'd1;
                            end
                            8'h05: begin
                                state_d = S_STAT;
                                tx_d    = STATUS_VAL;
                            end
                            8'h03: begin
                                state_d    = S_ADDR;
                                byte_cnt_d = 2'd0;
                            end
                            default: state_d = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_nxt;
                    end
                    if (byte_done) begin
                        if (byte_cnt_q == 2'd2) begin
                            state_d = S_DATA;
                            tx_d    = addr_nxt[7:0] ^ PATTERN;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_ID: begin
                    if (byte_done) begin
                        case (byte_cnt_q)
                            2'd1: begin
                                tx_d       = JEDEC_ID[15:8];
                                byte_cnt_d = 2'd2;
                            end
                            2'd2: begin
                                tx_d       = JEDEC_ID[7:0];
                                byte_cnt_d = 2'd3;
                            end
                            default: tx_d = 8'h00;
                        endcase
                    end
                end
                S_STAT: begin
                    if (byte_done) begin
                        tx_d = STATUS_VAL;
                    end
                end
                S_DATA: begin
                    if (byte_done) begin
                        addr_d = addr_inc;
                        tx_d   = addr_inc[7:0] ^ PATTERN;
                    end
                end
                S_IGNORE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign last_cmd    = last_cmd_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as a mode-0 initiator and checks ID, read, status,
// unknown-command, abort and mid-transfer reset behaviour at sck = clk/4 and clk/8.
module tb_spi_flash_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic cs_drv = 1'b1;
  logic sck_drv = 1'b0;
  logic mosi_drv = 1'b0;
  int   half = 2;

  spi_flash_responder_if spi0();
  spi_flash_responder_if spi1();
  assign spi0.cs = cs_drv;
  assign spi0.sck = sck_drv;
  assign spi0.mosi = mosi_drv;
  assign spi1.cs = cs_drv;
  assign spi1.sck = sck_drv;
  assign spi1.mosi = mosi_drv;

  logic       cmd_strobe0, busy0, cmd_strobe1, busy1;
  logic [7:0] last_cmd0, last_cmd1;
  logic [2:0] state0, state1;

  spi_flash_responder u_dut (
    .clk(clk), .rst_n(rst_n), .spi(spi0.slave),
    .cmd_strobe(cmd_strobe0), .last_cmd(last_cmd0), .busy(busy0), .dbg_state(state0)
  );

  spi_flash_responder #(.STATUS_VAL(8'h81)) u_dut81 (
    .clk(clk), .rst_n(rst_n), .spi(spi1.slave),
    .cmd_strobe(cmd_strobe1), .last_cmd(last_cmd1), .busy(busy1), .dbg_state(state1)
  );

  int checks = 0;
  int failures = 0;
  int strobe_total = 0;
  int oe_total = 0;

  always @(negedge clk) begin
    if (cmd_strobe0) strobe_total++;
    if (spi0.miso_oe) oe_total++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    @(negedge clk);
    sck_drv = 1'b0;
    cs_drv = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_end();
    sck_drv = 1'b0;
    wait_clk(half);
    cs_drv = 1'b1;
    wait_clk(6);
  endtask

  // Drives n bits MSB-first; miso is captured late in the high phase, after the resync latency.
  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] rx, output logic [7:0] rx81);
    rx = 8'h00;
    rx81 = 8'h00;
    for (int i = 0; i < n; i++) begin
      sck_drv = 1'b0;
      mosi_drv = tx[7-i];
      wait_clk(half);
      sck_drv = 1'b1;
      wait_clk(half);
      rx[7-i] = spi0.miso;
      rx81[7-i] = spi1.miso;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    checks++; if (spi0.miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi0.miso); end
    checks++; if (spi0.miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi0.miso_oe); end
    checks++; if (cmd_strobe0 !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", cmd_strobe0); end
    checks++; if (last_cmd0 !== 8'h00) begin failures++; $display("FAIL reset_last_cmd got=%h exp=00", last_cmd0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state0); end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_jedec_id(input string tag);
    logic [7:0] rx, rx81;
    logic [7:0] exp_id [3];
    int s0;
    exp_id = '{8'hEF, 8'h40, 8'h16};
    s0 = strobe_total;
    cs_start();
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", tag, busy0); end
    spi_bits(8'h9F, 8, rx, rx81);
    for (int b = 0; b < 3; b++) begin
      spi_bits(8'h00, 8, rx, rx81);
      checks++; if (rx !== exp_id[b]) begin failures++; $display("FAIL %s_byte%0d got=%h exp=%h", tag, b, rx, exp_id[b]); end
    end
    checks++; if (spi0.miso_oe !== 1'b1) begin failures++; $display("FAIL %s_oe got=%b exp=1", tag, spi0.miso_oe); end
    spi_bits(8'h00, 8, rx, rx81);
    checks++; if (rx !== 8'h00) begin failures++; $display("FAIL %s_pad got=%h exp=00", tag, rx); end
    cs_end();
    checks++; if (strobe_total - s0 !== 1) begin failures++; $display("FAIL %s_strobes got=%0d exp=1", tag, strobe_total - s0); end
    checks++; if (last_cmd0 !== 8'h9F) begin failures++; $display("FAIL %s_last_cmd got=%h exp=9f", tag, last_cmd0); end
    checks++; if (busy0 !== 1'b0 || spi0.miso_oe !== 1'b0) begin failures++; $display("FAIL %s_deselect busy=%b oe=%b exp=0,0", tag, busy0, spi0.miso_oe); end
  endtask

  task automatic test_read_wrap();
    logic [7:0] rx, rx81;
    logic [7:0] exp_d [4];
    exp_d = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    half = 4;
    cs_start();
    spi_bits(8'h03, 8, rx, rx81);
    spi_bits(8'hFF, 8, rx, rx81);
    spi_bits(8'hFF, 8, rx, rx81);
    spi_bits(8'hFE, 8, rx, rx81);
    for (int b = 0; b < 4; b++) begin
      spi_bits(8'h00, 8, rx, rx81);
      checks++; if (rx !== exp_d[b]) begin failures++; $display("FAIL read_wrap_byte%0d got=%h exp=%h", b, rx, exp_d[b]); end
    end
    cs_end();
    half = 2;
  endtask

  task automatic test_status();
    logic [7:0] rx, rx81;
    cs_start();
    spi_bits(8'h05, 8, rx, rx81);
    for (int b = 0; b < 3; b++) begin
      spi_bits(8'h00, 8, rx, rx81);
      checks++; if (rx !== 8'h00) begin failures++; $display("FAIL status00_byte%0d got=%h exp=00", b, rx); end
      checks++; if (rx81 !== 8'h81) begin failures++; $display("FAIL status81_byte%0d got=%h exp=81", b, rx81); end
    end
    cs_end();
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] rx, rx81;
    int oe0, s0;
    s0 = strobe_total;
    cs_start();
    spi_bits(8'h66, 8, rx, rx81);
    oe0 = oe_total;
    spi_bits(8'hFF, 8, rx, rx81);
    spi_bits(8'h5A, 8, rx, rx81);
    checks++; if (oe_total - oe0 !== 0) begin failures++; $display("FAIL unknown_oe got=%0d exp=0 cycles high", oe_total - oe0); end
    checks++; if (spi0.miso !== 1'b0) begin failures++; $display("FAIL unknown_miso got=%b exp=0", spi0.miso); end
    checks++; if (last_cmd0 !== 8'h66) begin failures++; $display("FAIL unknown_last_cmd got=%h exp=66", last_cmd0); end
    checks++; if (strobe_total - s0 !== 1) begin failures++; $display("FAIL unknown_strobes got=%0d exp=1", strobe_total - s0); end
    cs_end();
    test_jedec_id("after_unknown");
  endtask

  task automatic test_abort();
    logic [7:0] rx, rx81;
    int s0;
    s0 = strobe_total;
    cs_start();
    spi_bits(8'h03, 5, rx, rx81);
    cs_end();
    checks++; if (strobe_total - s0 !== 0) begin failures++; $display("FAIL abort_strobes got=%0d exp=0", strobe_total - s0); end
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state0); end
    checks++; if (last_cmd0 !== 8'h9F) begin failures++; $display("FAIL abort_last_cmd got=%h exp=9f", last_cmd0); end
    cs_start();
    spi_bits(8'h03, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    spi_bits(8'h10, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    checks++; if (rx !== 8'hB5) begin failures++; $display("FAIL abort_next_read got=%h exp=b5", rx); end
    cs_end();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx, rx81;
    half = 4;
    cs_start();
    spi_bits(8'h03, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    spi_bits(8'h00, 8, rx, rx81);
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL midreset_byte0 got=%h exp=a5", rx); end
    spi_bits(8'h00, 4, rx, rx81);
    checks++; if (spi0.miso_oe !== 1'b1 || busy0 !== 1'b1) begin failures++; $display("FAIL midreset_active oe=%b busy=%b exp=1,1", spi0.miso_oe, busy0); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (spi0.miso_oe !== 1'b0) begin failures++; $display("FAIL midreset_oe got=%b exp=0", spi0.miso_oe); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy0); end
    checks++; if (last_cmd0 !== 8'h00) begin failures++; $display("FAIL midreset_last_cmd got=%h exp=00", last_cmd0); end
    checks++; if (state0 !== 3'd0) begin failures++; $display("FAIL midreset_state got=%0d exp=0", state0); end
    checks++; if (spi0.miso !== 1'b0 || cmd_strobe0 !== 1'b0) begin failures++; $display("FAIL midreset_miso_strobe got=%b,%b exp=0,0", spi0.miso, cmd_strobe0); end
    sck_drv = 1'b0;
    cs_drv = 1'b1;
    mosi_drv = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    test_jedec_id("after_reset_clk8");
    half = 2;
  endtask

  initial begin
    test_reset();
    test_jedec_id("jedec_clk4");
    test_read_wrap();
    test_status();
    test_unknown_cmd();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
